// File: rtl/oled_msg_arbiter_if.sv
// rtl/oled_msg_arbiter_if.sv - character-stream handshake between the message arbiter and the OLED controller
interface oled_msg_arbiter_if;
    logic [7:0] sendData;
    logic       sendDataValid;
    logic       sendDone;

    // Arbiter side: drives characters, receives the controller acknowledge.
    modport master (
        output sendData,
        output sendDataValid,
        input  sendDone
    );

    // OLED controller side.
    modport slave (
        input  sendData,
        input  sendDataValid,
        output sendDone
    );
endinterface

// File: rtl/oled_msg_arbiter.sv
// rtl/oled_msg_arbiter.sv - round-robin arbiter streaming one snapshotted message at a time to the OLED controller
module oled_msg_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int STR_LEN = 64,
    parameter int IDX_W   = 7
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*STR_LEN*8-1:0] msg_flat,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    oled_msg_arbiter_if.master           oled
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MSG_W = STR_LEN * 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        SEND,
        FINISH
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   byte_cnt;
    logic [RR_W-1:0]    rr_last;
    logic [RR_W-1:0]    win_idx;
    logic [RR_W-1:0]    pick_idx;
    logic [RR_W-1:0]    cand;
    logic               pick_valid;
    logic [MSG_W-1:0]   snap;
    logic [7:0]         send_data;
    logic               send_valid;

    assign oled.sendData      = send_data;
    assign oled.sendDataValid = send_valid;

    // Round-robin pick: first requester at or after rr_last+1, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = RR_W'((int'(rr_last) + k) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Main FSM: grant and snapshot, then per-character valid/ack handshake, then done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            rr_last    <= RR_W'(NUM_REQ - 1);
            win_idx    <= '0;
            snap       <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            send_data  <= '0;
            send_valid <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= NUM_REQ'(1) << pick_idx;
                        busy     <= 1'b1;
                        snap     <= msg_flat[int'(pick_idx)*MSG_W +: MSG_W];
                        byte_cnt <= IDX_W'(STR_LEN);
                        win_idx  <= pick_idx;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // The controller must have dropped its previous ack before a new character goes out.
                    if (!oled.sendDone) begin
                        send_data  <= snap[int'(byte_cnt)*8-1 -: 8];
                        send_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (oled.sendDone) begin
                        send_valid <= 1'b0;
                        byte_cnt   <= byte_cnt - IDX_W'(1);
                        if (byte_cnt == IDX_W'(1)) begin
                            done  <= NUM_REQ'(1) << win_idx;
                            state <= FINISH;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                FINISH: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    rr_last <= win_idx;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/oled_msg_arbiter.md
Name: oled_msg_arbiter

Overview:
Shares the single OLED character-stream interface between NUM_REQ message sources, such as password-entry echo, access-granted/denied banner and lockout notice. A round-robin arbiter picks one requester and snapshots its STR_LEN-character message. It then streams the message byte by byte to the OLED controller over the sendData/sendDataValid/sendDone handshake, and signals completion to the winning requester. It sits between the password-system FSMs and the OLED controller, and replaces per-source string drivers.

Parameters:
NUM_REQ, 3, number of message requesters (2..8)
STR_LEN, 64, characters per message; each character is 8 bits
IDX_W, 7, width of the byte counter; must satisfy 2^IDX_W > STR_LEN

Ports:
clock  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester message request; level-sensitive
msg_flat  input  NUM_REQ*STR_LEN*8  concatenated messages; requester i occupies bits [(i+1)*STR_LEN*8-1 : i*STR_LEN*8]
grant  output  NUM_REQ  one-hot; high for the requester currently being streamed
done  output  NUM_REQ  one-cycle pulse on the served requester's bit at message completion
busy  output  1  high from grant until the done pulse, inclusive
sendData  output  8  character to the OLED controller
sendDataValid  output  1  character valid to the OLED controller
sendDone  input  1  OLED controller acknowledge; level signal, high after the character is written, low once ready again

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - grant=0, done=0, busy=0, sendData=0, sendDataValid=0.
  - state=IDLE, byte_cnt=0.
  - rr_last=NUM_REQ-1, so requester 0 has first priority after reset.
- States: IDLE, WAIT_RDY, SEND, FINISH.
- IDLE:
  - If req != 0, choose the first set bit scanning from rr_last+1 upward with wrap-around.
  - On the next edge: grant=onehot(winner), busy=1, snapshot the winner's msg_flat slice into an internal STR_LEN*8 register, byte_cnt=STR_LEN, go to WAIT_RDY.
  - No grant when req==0.
- WAIT_RDY:
  - If sendDone==0: sendData=snap[byte_cnt*8-1 -: 8], sendDataValid=1, go to SEND.
  - Otherwise hold here with sendDataValid=0.
- SEND:
  - Hold sendData and sendDataValid stable until sendDone==1.
  - On sendDone==1: sendDataValid=0 and byte_cnt=byte_cnt-1.
  - If byte_cnt was 1, go to FINISH; otherwise go to WAIT_RDY.
- FINISH, one cycle:
  - done[winner]=1 for exactly this cycle.
  - grant=0, busy=0, rr_last=winner.
  - Return to IDLE. The earliest next grant is the edge after returning to IDLE.
- Byte order: most-significant character first, i.e. string-literal order. Character 0 is bits [STR_LEN*8-1 -: 8] of the slice.
- Per-character cost: at least 2 clocks plus OLED controller latency. sendDataValid is never high in two consecutive characters without an intervening low cycle.
- Message content is the snapshot taken at grant. Changes on msg_flat during streaming are ignored.
- req deasserted mid-message: the message completes and done still pulses. There is no abort.
- req still high after done: the requester re-enters arbitration normally. Because rr_last moved to it, any other pending requester wins first.
- Simultaneous requests: exactly one grant, chosen by round-robin order; never more than one grant bit set.
- sendDone already high on entry to WAIT_RDY: wait. No character is issued until sendDone is low.
- Reset asserted mid-message: all outputs clear immediately and no done pulse occurs. After release, the next arbitration starts from requester 0.
- grant bits for out-of-range or absent requesters are never set.

Test Plan:
- Reset release, req=3'b001, msg0 = "PASSWORD OK" padded with spaces to 64 chars, OLED model acks 3 cycles after valid -> 64 bytes issued in order 'P','A','S',... Each valid drops the cycle after sendDone. done=3'b001 for one cycle. busy low the cycle after the done pulse.
- req=3'b111 held continuously -> grant sequence 001, 010, 100, 001. Each grant is followed by 64 characters and its done pulse; never two grant bits set at once.
- req[0] held and req[1] asserted mid-transfer of msg0 -> requester 1 is granted right after done[0]. Requester 0 is served again only after done[1].
- req[2] pulsed for 1 cycle in IDLE, then msg2 changed to all 'X' mid-stream -> the full original msg2 is sent, then done[2] pulses.
- OLED model holds sendDone high for 10 cycles after the grant -> sendDataValid stays 0 until sendDone falls. The first character is then issued.
- reset_n driven low at character 30 of msg1 -> grant, busy and sendDataValid are 0 immediately with no done pulse. After release with req=3'b011, requester 0 is granted first.
